// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        LD_HDR,
        LD_DATA,
        LD_DONE,
        LD_ERR
    } ld_state_t;

    // Length header is one little-endian 32-bit word.
    localparam int HDR_BYTES = 4;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Memory write port driven by the boot loader while the CPU is held.
interface uart_boot_loader_if;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (output mem_we, mem_addr, mem_wdata);
    modport slave  (input  mem_we, mem_addr, mem_wdata);

endinterface

// File: rtl/uart_boot_loader_rx_core.sv
// 8N1 UART receiver: input synchronizer, bit timing and byte framing.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RX_IDLE  | line idle, waiting for a synced low
// RX_START | half-bit wait, then confirm start bit (high = glitch)
// RX_BITS  | sample 8 data bits, one per bit period, LSB first
// RX_STOP  | sample stop bit; pulse byte_valid (high) or frame_err (low)
module uart_rx_core
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] rx_byte
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_TC = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_TC = TW'(CLKS_PER_BIT / 2 - 1);

    logic            rx_meta;
    logic            rx_sync;
    rx_state_t       state;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;

    assign rx_byte = shift_reg;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // Receiver FSM; timer is a down-counter that fires on terminal count zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        state <= RX_START;
                        timer <= HALF_TC;
                    end
                end
                RX_START: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (rx_sync) begin
                        state <= RX_IDLE;
                    end else begin
                        state   <= RX_BITS;
                        timer   <= FULL_TC;
                        bit_cnt <= 3'd7;
                    end
                end
                RX_BITS: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        shift_reg <= {rx_sync, shift_reg[7:1]};
                        timer     <= FULL_TC;
                        if (bit_cnt == 3'd0) begin
                            state <= RX_STOP;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        // Back to idle right at the stop sample so a
                        // following start edge is not missed.
                        byte_valid <= rx_sync;
                        frame_err  <= !rx_sync;
                        state      <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader top: receives a length-prefixed image over UART, writes it
// into word-addressed memory, then releases the CPU.
//
// state   | meaning
// --------+------------------------------------------------------------
// LD_HDR  | collecting 4-byte little-endian word count N
// LD_DATA | assembling words, one memory write per 4 bytes
// LD_DONE | image loaded, cpu_run high, UART ignored until reset
// LD_ERR  | framing error or oversize image, load_err held until reset
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int MEM_WORDS    = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       uart_rx,
    uart_boot_loader_if.master         mem,
    output logic                       cpu_run,
    output logic                       load_err
);

    logic        byte_valid;
    logic        frame_err;
    logic [7:0]  rx_byte;

    ld_state_t   state;
    logic [1:0]  lane;
    logic [31:0] word_idx;
    logic [31:0] word_total;
    logic [23:0] word_buf;
    logic [31:0] word_full;

    // Word as it stands once the current byte lands in the top lane.
    assign word_full = {rx_byte, word_buf};

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .rx_byte    (rx_byte)
    );

    // Loader FSM with registered memory port and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= LD_HDR;
            lane          <= '0;
            word_idx      <= '0;
            word_total    <= '0;
            word_buf      <= '0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            cpu_run       <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            mem.mem_we <= 1'b0;
            case (state)
                LD_HDR, LD_DATA: begin
                    if (frame_err) begin
                        // Partial word is simply abandoned; no write issued.
                        state    <= LD_ERR;
                        load_err <= 1'b1;
                        cpu_run  <= 1'b0;
                    end else if (byte_valid) begin
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0:    word_buf[7:0]   <= rx_byte;
                            2'd1:    word_buf[15:8]  <= rx_byte;
                            2'd2:    word_buf[23:16] <= rx_byte;
                            default: ;
                        endcase
                        if (lane == 2'(HDR_BYTES - 1)) begin
                            if (state == LD_HDR) begin
                                if (word_full == 32'd0) begin
                                    state   <= LD_DONE;
                                    cpu_run <= 1'b1;
                                end else if (word_full > 32'(MEM_WORDS)) begin
                                    state    <= LD_ERR;
                                    load_err <= 1'b1;
                                end else begin
                                    state      <= LD_DATA;
                                    word_total <= word_full;
                                    lane       <= '0;
                                    word_idx   <= '0;
                                end
                            end else begin
                                mem.mem_we    <= 1'b1;
                                mem.mem_addr  <= word_idx;
                                mem.mem_wdata <= word_full;
                                word_idx      <= word_idx + 32'd1;
                                // cpu_run follows one cycle later from LD_DONE.
                                if (word_idx == word_total - 32'd1) begin
                                    state <= LD_DONE;
                                end
                            end
                        end
                    end
                end
                LD_DONE: begin
                    cpu_run <= 1'b1;
                end
                LD_ERR: begin
                    load_err <= 1'b1;
                    cpu_run  <= 1'b0;
                end
                default: state <= LD_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: table of byte streams plus
// hand-written glitch, reset-mid-load and full-depth sequences.
module tb_uart_boot_loader;

    localparam int CPB = 4;
    localparam int MW  = 16;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic uart_rx = 1'b1;
    logic cpu_run;
    logic load_err;

    uart_boot_loader_if mem_bus ();

    uart_boot_loader #(
        .CLKS_PER_BIT(CPB),
        .MEM_WORDS   (MW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .mem      (mem_bus),
        .cpu_run  (cpu_run),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                nbytes;
        logic [11:0][7:0]  bytes;
        int                bad_idx;
        int                exp_nw;
        logic [3:0][31:0]  exp_words;
        logic              exp_run;
        logic              exp_err;
    } vec_t;

    vec_t vecs [5];

    int checks   = 0;
    int failures = 0;

    int          cycle     = 0;
    logic        mon_clear = 1'b1;
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          wr_cyc_q  [$];
    int          bv_cyc_q  [$];
    int          run_rise  = -1;
    int          both_hi   = 0;
    logic        run_prev  = 1'b0;
    logic [31:0] exp_q     [$];

    // Observe the DUT away from the active edge.
    always @(negedge clk) begin
        cycle++;
        if (mon_clear) begin
            wr_addr_q.delete();
            wr_data_q.delete();
            wr_cyc_q.delete();
            bv_cyc_q.delete();
            run_rise = -1;
            both_hi  = 0;
            run_prev = 1'b0;
        end else begin
            if (mem_bus.mem_we) begin
                wr_addr_q.push_back(mem_bus.mem_addr);
                wr_data_q.push_back(mem_bus.mem_wdata);
                wr_cyc_q.push_back(cycle);
            end
            if (dut.u_rx.byte_valid) bv_cyc_q.push_back(cycle);
            if (cpu_run && !run_prev) run_rise = cycle;
            if (cpu_run && load_err) both_hi++;
            run_prev = cpu_run;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        if (!stop) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        uart_rx   = 1'b1;
        mon_clear = 1'b1;
        repeat (4) @(negedge clk);
        rst_n     = 1'b1;
        mon_clear = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rst mem_we"},    32'(mem_bus.mem_we), 32'd0);
        check({tag, " rst mem_addr"},  mem_bus.mem_addr,    32'd0);
        check({tag, " rst mem_wdata"}, mem_bus.mem_wdata,   32'd0);
        check({tag, " rst cpu_run"},   32'(cpu_run),        32'd0);
        check({tag, " rst load_err"},  32'(load_err),       32'd0);
    endtask

    // Compare captured writes and status against exp_q / expected flags.
    task automatic verify(input string tag, input logic exp_run, input logic exp_err, input int hold);
        int n;
        int bad;
        repeat (30) @(negedge clk);
        n = exp_q.size();
        check({tag, " write count"}, 32'(wr_addr_q.size()), 32'(n));
        for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
            check($sformatf("%s addr[%0d]", tag, k), wr_addr_q[k], 32'(k));
            check($sformatf("%s data[%0d]", tag, k), wr_data_q[k], exp_q[k]);
        end
        check({tag, " cpu_run"},  32'(cpu_run),  32'(exp_run));
        check({tag, " load_err"}, 32'(load_err), 32'(exp_err));
        check({tag, " run&err overlap"}, 32'(both_hi), 32'd0);
        if (exp_run && n > 0 && wr_cyc_q.size() == n) begin
            check({tag, " run after last we"}, 32'(run_rise), 32'(wr_cyc_q[n-1] + 1));
            check({tag, " addr hold"},  mem_bus.mem_addr,  32'(n - 1));
            check({tag, " wdata hold"}, mem_bus.mem_wdata, exp_q[n-1]);
        end else if (exp_run && n == 0) begin
            if (bv_cyc_q.size() >= 4)
                check({tag, " run after hdr"}, 32'(run_rise), 32'(bv_cyc_q[3] + 1));
            else
                check({tag, " hdr byte_valid count"}, 32'(bv_cyc_q.size()), 32'd4);
        end else if (!exp_run) begin
            check({tag, " cpu_run never rose"}, 32'(run_rise), 32'hFFFF_FFFF);
        end
        if (hold > 0) begin
            bad = 0;
            repeat (hold) begin
                @(negedge clk);
                if (cpu_run !== exp_run || load_err !== exp_err) bad++;
            end
            check({tag, " hold status"}, 32'(bad), 32'd0);
            check({tag, " hold writes"}, 32'(wr_addr_q.size()), 32'(n));
        end
    endtask

    initial begin
        vecs[0] = '{nbytes: 12,
                    bytes: {8'h00, 8'h10, 8'h05, 8'h93, 8'h00, 8'hA0, 8'h05, 8'h13,
                            8'h00, 8'h00, 8'h00, 8'h02},
                    bad_idx: -1, exp_nw: 2,
                    exp_words: {32'h0, 32'h0, 32'h0010_0593, 32'h00A0_0513},
                    exp_run: 1'b1, exp_err: 1'b0};
        vecs[1] = '{nbytes: 8,
                    bytes: {32'h0, 8'h02, 8'h01, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00},
                    bad_idx: -1, exp_nw: 0, exp_words: '0,
                    exp_run: 1'b1, exp_err: 1'b0};
        vecs[2] = '{nbytes: 4,
                    bytes: {64'h0, 8'h00, 8'h00, 8'h00, 8'h11},
                    bad_idx: -1, exp_nw: 0, exp_words: '0,
                    exp_run: 1'b0, exp_err: 1'b1};
        vecs[3] = '{nbytes: 7,
                    bytes: {8'h00, 8'h10, 8'h05, 8'h93, 8'h00, 8'hA0, 8'h05, 8'h13,
                            8'h00, 8'h00, 8'h00, 8'h02},
                    bad_idx: 6, exp_nw: 0, exp_words: '0,
                    exp_run: 1'b0, exp_err: 1'b1};
        vecs[4] = '{nbytes: 8,
                    bytes: {32'h0, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01},
                    bad_idx: -1, exp_nw: 1,
                    exp_words: {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF},
                    exp_run: 1'b1, exp_err: 1'b0};

        do_reset();
        @(negedge clk);
        check_reset_outputs("init");

        for (int v = 0; v < 5; v++) begin
            do_reset();
            exp_q.delete();
            for (int k = 0; k < vecs[v].exp_nw; k++) exp_q.push_back(vecs[v].exp_words[k]);
            for (int i = 0; i < vecs[v].nbytes; i++)
                send_byte(vecs[v].bytes[i], (i != vecs[v].bad_idx));
            verify($sformatf("vec%0d", v), vecs[v].exp_run, vecs[v].exp_err, 1000);
        end

        // One-cycle low pulse while idle must not start a frame.
        do_reset();
        repeat (3) @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch byte_valid count", 32'(bv_cyc_q.size()), 32'd0);
        exp_q.delete();
        exp_q.push_back(32'hCAFE_F00D);
        send_word(32'd1);
        send_word(32'hCAFE_F00D);
        verify("glitch", 1'b1, 1'b0, 0);

        // Reset after five data bytes, then a clean reload.
        do_reset();
        send_word(32'd2);
        send_word(32'h00A0_0513);
        send_byte(8'h93, 1'b1);
        repeat (20) @(negedge clk);
        check("midload write count", 32'(wr_addr_q.size()), 32'd1);
        check("midload cpu_run",     32'(cpu_run),          32'd0);
        do_reset();
        @(negedge clk);
        check_reset_outputs("midload");
        exp_q.delete();
        exp_q.push_back(32'hDEAD_BEEF);
        send_word(32'd1);
        send_word(32'hDEAD_BEEF);
        verify("reload", 1'b1, 1'b0, 0);

        // Full-depth image: N == MEM_WORDS is legal, last address MW-1.
        do_reset();
        exp_q.delete();
        send_word(32'(MW));
        for (int k = 0; k < MW; k++) begin
            exp_q.push_back(32'h1000_0000 | (32'(k) * 32'h0000_0101));
            send_word(32'h1000_0000 | (32'(k) * 32'h0000_0101));
        end
        verify("full", 1'b1, 1'b0, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Loads a program image into the CPU's unified word-addressed memory over a UART link and holds the CPU stalled until the load completes. It sits directly upstream of the CPU and memory. It drives the memory write port during boot, then releases the CPU via `cpu_run`. On the FPGA it replaces loading the image from a file in simulation.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868 — clock cycles per UART bit (100 MHz / 115200); legal values ≥ 4
- `MEM_WORDS`, 1024 — memory depth in 32-bit words; maximum loadable image size

Ports:
- `clk`  in  1  — single system clock; all logic on posedge
- `rst_n`  in  1  — synchronous, active-low reset
- `uart_rx`  in  1  — asynchronous serial input, idle high, 8N1, LSB first
- `mem_we`  out  1  — one-cycle write strobe to memory
- `mem_addr`  out  32  — word index, same encoding as the CPU memory address
- `mem_wdata`  out  32  — word to write
- `cpu_run`  out  1  — high = CPU may execute; gate the CPU clock enable or reset with it
- `load_err`  out  1  — sticky error flag

## Operation
- `uart_rx` passes through a 2-flop synchronizer. All decoding uses the synchronized value.
- Receiver FSM:
  - `RX_IDLE`: a synced low moves to `RX_START`.
  - `RX_START`: wait `CLKS_PER_BIT/2` cycles, then resample. If the line is high, the start was false: return to `RX_IDLE` with no byte. If low, go to `RX_BITS`.
  - `RX_BITS`: sample every `CLKS_PER_BIT` cycles, 8 times, shifting in LSB first.
  - `RX_STOP`: sample after `CLKS_PER_BIT` cycles. High produces a one-cycle `byte_valid` pulse; low produces a one-cycle `frame_err` pulse. Either way return to `RX_IDLE` in the same cycle, so back-to-back frames are accepted.
- Loader FSM:
  - `LD_HDR`: collect 4 bytes, little-endian, as word count N.
    - N == 0 → `LD_DONE`.
    - N > `MEM_WORDS` → `LD_ERR`.
    - Otherwise → `LD_DATA`.
  - `LD_DATA`: assemble 4 bytes little-endian into a word. On the 4th byte, write the word to `mem_addr` = word counter, then increment the counter. After word N-1 is written, go to `LD_DONE`.
  - `LD_DONE`: `cpu_run` = 1. `uart_rx` is ignored until reset.
  - `LD_ERR`: `load_err` = 1 and `cpu_run` = 0. Held until reset.
- A `frame_err` in `LD_HDR` or `LD_DATA` → `LD_ERR`. Any partially assembled word is discarded and no write occurs.
- Byte lane counter (2 bits) and word counter (32 bits) clear on entry to `LD_HDR` and `LD_DATA`.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_run`=0, `load_err`=0. Loader enters `LD_HDR`, receiver enters `RX_IDLE`, all counters are 0.
- Reset mid-load aborts everything. Memory already written is not cleared. The next load restarts at address 0.
- Input latency: 2 synchronizer cycles plus frame time.
- `byte_valid` is asserted in the cycle after the stop-bit sample.
- `mem_we`, `mem_addr` and `mem_wdata` are registered and valid together for exactly one cycle. That cycle is the one after `byte_valid` for byte 3 of each word.
- `mem_addr` and `mem_wdata` hold their last values while `mem_we`=0.
- `cpu_run` rises in the cycle after the final `mem_we`. For N == 0, it rises in the cycle after the 4th header `byte_valid`.
- `cpu_run` and `load_err` are never both 1.
- Word counter comparison uses 32-bit unsigned arithmetic. N == `MEM_WORDS` is legal: the last address written is `MEM_WORDS-1`.

## Structure
- Package `boot_pkg`:
  - `rx_state_t` enum {`RX_IDLE`, `RX_START`, `RX_BITS`, `RX_STOP`}
  - `ld_state_t` enum {`LD_HDR`, `LD_DATA`, `LD_DONE`, `LD_ERR`}
  - constant `HDR_BYTES` = 4
- Sub-module `uart_rx_core` contains the synchronizer, receiver FSM and bit counter.
  - Outputs: `byte_valid`, `frame_err`, `rx_byte[7:0]`.
  - Parameter: `CLKS_PER_BIT`.
- The top level contains the loader FSM and the word assembly logic.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `MEM_WORDS`=16.
- Normal load: send `02 00 00 00 13 05 A0 00 93 05 10 00`. Expect `mem_we` at addr 0 with 0x00A00513, then at addr 1 with 0x00100593. `cpu_run`=1 one cycle after the second write. No further writes.
- Zero-length header: send `00 00 00 00`. Expect no `mem_we` and `cpu_run` rising 1 cycle after the 4th `byte_valid`. Extra bytes sent afterwards produce no writes.
- Oversize header: send `11 00 00 00` (N=17). Expect `load_err`=1, `cpu_run`=0, no `mem_we`, and the state held for 1000 cycles.
- Framing error: header N=2, then drive the stop bit low on data byte 2. Expect `load_err`=1 and no `mem_we` ever.
- Glitch rejection: hold `uart_rx` low for 1 cycle while idle. Expect no `byte_valid`, followed by a normal load of N=1 that succeeds.
- Reset mid-load: with N=2, apply reset after 5 data bytes. Then perform a full reload of N=1 with 0xDEADBEEF. Expect the write at addr 0, then `cpu_run`=1.
